stack_controller: RTL and testbench
===================================

STACK_CONTROLLER -- requirements
Module: stack_controller

Interface
REQ-001 CLK  in  1  single system clock; all state changes on rising edge.
REQ-002 RESET  in  1  asynchronous, active-high reset.
REQ-003 Run  in  1  level; 1 = permit instruction fetch, 0 = hold in S_FETCH.
REQ-004 IROut  in  16  instruction register; opcode = IROut[15:12].
REQ-005 ValAOut  in  16  ValA register; zero test for BZ.
REQ-006 PCWrite, PCSource, PCAdd  out  1 each  PC controls; PCSource 0 = incrementer, 1 = ValA; PCAdd 0 = +1, 1 = +SignExt.
REQ-007 MSPWrite, MSPop, RSPWrite, RSPop  out  1 each  stack pointer controls; op 0 = increment, 1 = decrement.
REQ-008 PCRegReset, MSPRegReset, RSPRegReset  out  1 each  datapath register resets.
REQ-009 ValAWrite, ValBWrite, IRWrite, displayWrite  out  1 each  register load enables.
REQ-010 MemRead1, MemRead2, MemWrite1, MemWrite2  out  1 each  memory port strobes.
REQ-011 MemDst1  out  2  00 = PC, 01 = MSP, 10 = RSP.
REQ-012 MemDst2  out  2  00 = MSP, 01 = RSP.
REQ-013 MemData  out  3  000 = PC, 001 = Res, 010 = ZEImm.
REQ-014 Halted, Illegal  out  1 each  sticky status flags.
REQ-015 State  out  5  current state encoding, debug only.

Function
REQ-016 Stack convention: MSP/RSP point at next free word; push = write at pointer, then increment; pop = decrement, then read at pointer.
REQ-017 Memory read data SHALL be captured into ValA (port 1) or ValB (port 2) on the same CLK edge that ends the MemReadN cycle.
REQ-018 All outputs SHALL be registered-state decodes (Moore); every strobe not listed for a state is 0; selects not listed are 0.
REQ-019 S_INIT: assert all three RegResets; next S_FETCH.
REQ-020 S_FETCH: if Run=0, all strobes 0, stay; if Run=1, MemRead1, MemDst1=00, IRWrite, PCWrite (PCSource=0, PCAdd=0); next S_DECODE.
REQ-021 S_DECODE: no strobes; branch on opcode per REQ-022..REQ-029.
REQ-022 0x0 ALU: POPA_DEC -> POPA_RD -> POPB_DEC -> POPB_RD -> S_ALU (1 wait cycle) -> PUSH_WR (MemData=001) -> PUSH_INC -> S_FETCH; 9 cycles total.
REQ-023 POPx_DEC: MSPWrite, MSPop=1; POPA_RD: MemRead1, MemDst1=01, ValAWrite; POPB_RD: MemRead2, MemDst2=00, ValBWrite.
REQ-024 0x1 PUSHI: PUSH_WR (MemWrite1, MemDst1=01, MemData=010) -> PUSH_INC (MSPWrite, MSPop=0) -> S_FETCH; 4 cycles.
REQ-025 0x2 POP: POPA_DEC -> POPA_RD -> S_FETCH.
REQ-026 0x3 JMP: S_BRANCH (PCWrite, PCAdd=1) -> S_FETCH; target = incremented PC + SignExt.
REQ-027 0x4 BZ: POPA_DEC -> POPA_RD -> S_BZTEST; if ValAOut==0 go to S_BRANCH, else S_FETCH.
REQ-028 0x5 CALL: S_CALL_WR (MemWrite2, MemDst2=01, MemData=000) -> S_CALL_JMP (RSPWrite, RSPop=0, PCWrite, PCAdd=1) -> S_FETCH.
REQ-029 0x6 RET: S_RET_DEC (RSPWrite, RSPop=1) -> S_RET_RD (MemRead1, MemDst1=10, ValAWrite) -> S_RET_JMP (PCWrite, PCSource=1) -> S_FETCH.
REQ-030 0x8 DISP: POPA_DEC -> POPA_RD -> S_DISP (displayWrite) -> S_FETCH.
REQ-031 0x7 HALT: S_HALT, Halted=1, all strobes 0; exit only by RESET.
REQ-032 Opcodes 0x9-0xF: S_ILLEGAL, Illegal=1, all strobes 0; exit only by RESET.
REQ-033 Run deasserted mid-instruction SHALL NOT stall; Run is sampled only in S_FETCH.
REQ-034 Pointer wrap (0x0000 decrement, 0xFFFF increment) is not detected; controller issues strobes unchanged.
REQ-035 No state SHALL assert MemWrite and MemRead on the same port, or PCWrite with IRWrite outside S_FETCH.

Reset
REQ-036 RESET=1 SHALL force S_INIT immediately (asynchronous), with all three RegResets=1 and every other output 0, including mid-instruction.
REQ-037 Halted and Illegal SHALL clear only on RESET.
REQ-038 After RESET release, exactly one S_INIT cycle precedes the first S_FETCH.

Verification
REQ-039 Reset, Run=1, IR=0x1005 (PUSHI 5): S_INIT, FETCH, DECODE, PUSH_WR with MemData=010 and MemWrite1, PUSH_INC with MSPWrite/MSPop=0, back to FETCH.
REQ-040 IR=0x0000 (ALU): 9-cycle sequence; MSPWrite/MSPop=1 twice, ValAWrite then ValBWrite, MemWrite1 with MemData=001.
REQ-041 IR=0x4003, ValAOut=0 at BZTEST -> S_BRANCH with PCAdd=1; repeat with ValAOut=0x0001 -> no PCWrite after FETCH.
REQ-042 CALL (0x5010) then RET (0x6000): MemWrite2 with MemDst2=01, MemData=000; RET asserts MemDst1=10, then PCSource=1 with PCWrite.
REQ-043 IR=0xA000 -> Illegal=1, strobes 0 for 20 cycles; RESET asserted mid-ALU sequence -> outputs reach S_INIT values before next CLK edge.

Source files
------------

// File: rtl/stack_controller.sv
// Multi-cycle control FSM for a dual-stack (data + return) processor.
// Every output is a decode of the current state; only FETCH also looks at Run.
module stack_controller (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        Run,
    input  logic [15:0] IROut,
    input  logic [15:0] ValAOut,
    output logic        PCWrite,
    output logic        PCSource,
    output logic        PCAdd,
    output logic        MSPWrite,
    output logic        MSPop,
    output logic        RSPWrite,
    output logic        RSPop,
    output logic        PCRegReset,
    output logic        MSPRegReset,
    output logic        RSPRegReset,
    output logic        ValAWrite,
    output logic        ValBWrite,
    output logic        IRWrite,
    output logic        displayWrite,
    output logic        MemRead1,
    output logic        MemRead2,
    output logic        MemWrite1,
    output logic        MemWrite2,
    output logic [1:0]  MemDst1,
    output logic [1:0]  MemDst2,
    output logic [2:0]  MemData,
    output logic        Halted,
    output logic        Illegal,
    output logic [4:0]  State
);

    typedef enum logic [4:0] {
        S_INIT, S_FETCH, S_DECODE,
        S_POPA_DEC, S_POPA_RD, S_POPB_DEC, S_POPB_RD,
        S_ALU, S_PUSH_WR, S_PUSH_INC,
        S_BRANCH, S_BZTEST,
        S_CALL_WR, S_CALL_JMP,
        S_RET_DEC, S_RET_RD, S_RET_JMP,
        S_DISP, S_HALT, S_ILLEGAL
    } state_t;

    localparam logic [3:0] OP_ALU  = 4'h0;
    localparam logic [3:0] OP_PUSH = 4'h1;
    localparam logic [3:0] OP_POP  = 4'h2;
    localparam logic [3:0] OP_JMP  = 4'h3;
    localparam logic [3:0] OP_BZ   = 4'h4;
    localparam logic [3:0] OP_CALL = 4'h5;
    localparam logic [3:0] OP_RET  = 4'h6;
    localparam logic [3:0] OP_HALT = 4'h7;
    localparam logic [3:0] OP_DISP = 4'h8;

    state_t     state_q, state_d;
    logic [3:0] opcode;
    logic       unusedIrBits;

    assign opcode       = IROut[15:12];
    assign unusedIrBits = ^IROut[11:0];
    assign State        = state_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= S_INIT;
        else       state_q <= state_d;
    end

    // POPA_RD is shared by ALU, POP, BZ and DISP, so it re-examines the opcode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_INIT:     state_d = S_FETCH;
            S_FETCH:    if (Run) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_ALU, OP_POP, OP_BZ, OP_DISP: state_d = S_POPA_DEC;
                    OP_PUSH: state_d = S_PUSH_WR;
                    OP_JMP:  state_d = S_BRANCH;
                    OP_CALL: state_d = S_CALL_WR;
                    OP_RET:  state_d = S_RET_DEC;
                    OP_HALT: state_d = S_HALT;
                    default: state_d = S_ILLEGAL;
                endcase
            end
            S_POPA_DEC: state_d = S_POPA_RD;
            S_POPA_RD: begin
                case (opcode)
                    OP_ALU:  state_d = S_POPB_DEC;
                    OP_BZ:   state_d = S_BZTEST;
                    OP_DISP: state_d = S_DISP;
                    default: state_d = S_FETCH;
                endcase
            end
            S_POPB_DEC: state_d = S_POPB_RD;
            S_POPB_RD:  state_d = S_ALU;
            S_ALU:      state_d = S_PUSH_WR;
            S_PUSH_WR:  state_d = S_PUSH_INC;
            S_PUSH_INC: state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_BZTEST:   state_d = (ValAOut == 16'h0000) ? S_BRANCH : S_FETCH;
            S_CALL_WR:  state_d = S_CALL_JMP;
            S_CALL_JMP: state_d = S_FETCH;
            S_RET_DEC:  state_d = S_RET_RD;
            S_RET_RD:   state_d = S_RET_JMP;
            S_RET_JMP:  state_d = S_FETCH;
            S_DISP:     state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            S_ILLEGAL:  state_d = S_ILLEGAL;
            default:    state_d = S_INIT;
        endcase
    end

    // PUSH_WR serves both ALU results and immediates; the opcode picks the source.
    always_comb begin
        PCWrite      = 1'b0;
        PCSource     = 1'b0;
        PCAdd        = 1'b0;
        MSPWrite     = 1'b0;
        MSPop        = 1'b0;
        RSPWrite     = 1'b0;
        RSPop        = 1'b0;
        PCRegReset   = 1'b0;
        MSPRegReset  = 1'b0;
        RSPRegReset  = 1'b0;
        ValAWrite    = 1'b0;
        ValBWrite    = 1'b0;
        IRWrite      = 1'b0;
        displayWrite = 1'b0;
        MemRead1     = 1'b0;
        MemRead2     = 1'b0;
        MemWrite1    = 1'b0;
        MemWrite2    = 1'b0;
        MemDst1      = 2'b00;
        MemDst2      = 2'b00;
        MemData      = 3'b000;
        Halted       = 1'b0;
        Illegal      = 1'b0;
        unique case (state_q)
            S_INIT: begin
                PCRegReset  = 1'b1;
                MSPRegReset = 1'b1;
                RSPRegReset = 1'b1;
            end
            S_FETCH: begin
                if (Run) begin
                    MemRead1 = 1'b1;
                    IRWrite  = 1'b1;
                    PCWrite  = 1'b1;
                end
            end
            S_POPA_DEC, S_POPB_DEC: begin
                MSPWrite = 1'b1;
                MSPop    = 1'b1;
            end
            S_POPA_RD: begin
                MemRead1  = 1'b1;
                MemDst1   = 2'b01;
                ValAWrite = 1'b1;
            end
            S_POPB_RD: begin
                MemRead2  = 1'b1;
                ValBWrite = 1'b1;
            end
            S_PUSH_WR: begin
                MemWrite1 = 1'b1;
                MemDst1   = 2'b01;
                MemData   = (opcode == OP_ALU) ? 3'b001 : 3'b010;
            end
            S_PUSH_INC: MSPWrite = 1'b1;
            S_BRANCH: begin
                PCWrite = 1'b1;
                PCAdd   = 1'b1;
            end
            S_CALL_WR: begin
                MemWrite2 = 1'b1;
                MemDst2   = 2'b01;
            end
            S_CALL_JMP: begin
                RSPWrite = 1'b1;
                PCWrite  = 1'b1;
                PCAdd    = 1'b1;
            end
            S_RET_DEC: begin
                RSPWrite = 1'b1;
                RSPop    = 1'b1;
            end
            S_RET_RD: begin
                MemRead1  = 1'b1;
                MemDst1   = 2'b10;
                ValAWrite = 1'b1;
            end
            S_RET_JMP: begin
                PCWrite  = 1'b1;
                PCSource = 1'b1;
            end
            S_DISP:    displayWrite = 1'b1;
            S_HALT:    Halted = 1'b1;
            S_ILLEGAL: Illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_stack_controller.sv
// Scoreboard bench for stack_controller: instructions are expanded into per-cycle
// expected control words from the instruction table, and a negedge monitor checks them.
module tb_stack_controller;

    typedef struct packed {
        logic       PCWrite, PCSource, PCAdd, MSPWrite, MSPop, RSPWrite, RSPop;
        logic       PCRegReset, MSPRegReset, RSPRegReset;
        logic       ValAWrite, ValBWrite, IRWrite, displayWrite;
        logic       MemRead1, MemRead2, MemWrite1, MemWrite2;
        logic [1:0] MemDst1, MemDst2;
        logic [2:0] MemData;
        logic       Halted, Illegal;
    } outs_t;

    typedef enum int {
        K_ZERO, K_INIT, K_FETCH, K_POP_DEC, K_POPA_RD, K_POPB_RD,
        K_PUSH_ALU, K_PUSH_IMM, K_PUSH_INC, K_BRANCH, K_CALL_WR, K_CALL_JMP,
        K_RET_DEC, K_RET_RD, K_RET_JMP, K_DISP, K_HALT, K_ILL
    } kind_t;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        Run = 1'b0;
    logic [15:0] IROut = 16'h0000;
    logic [15:0] ValAOut = 16'h0000;
    logic        PCWrite, PCSource, PCAdd, MSPWrite, MSPop, RSPWrite, RSPop;
    logic        PCRegReset, MSPRegReset, RSPRegReset;
    logic        ValAWrite, ValBWrite, IRWrite, displayWrite;
    logic        MemRead1, MemRead2, MemWrite1, MemWrite2;
    logic [1:0]  MemDst1, MemDst2;
    logic [2:0]  MemData;
    logic        Halted, Illegal;
    logic [4:0]  State;

    outs_t actual;
    outs_t expQ[$];
    string tagQ[$];
    int    nChecks = 0;
    int    nPass = 0;

    stack_controller dut (
        .CLK(CLK), .RESET(RESET), .Run(Run), .IROut(IROut), .ValAOut(ValAOut),
        .PCWrite(PCWrite), .PCSource(PCSource), .PCAdd(PCAdd),
        .MSPWrite(MSPWrite), .MSPop(MSPop), .RSPWrite(RSPWrite), .RSPop(RSPop),
        .PCRegReset(PCRegReset), .MSPRegReset(MSPRegReset), .RSPRegReset(RSPRegReset),
        .ValAWrite(ValAWrite), .ValBWrite(ValBWrite), .IRWrite(IRWrite),
        .displayWrite(displayWrite),
        .MemRead1(MemRead1), .MemRead2(MemRead2),
        .MemWrite1(MemWrite1), .MemWrite2(MemWrite2),
        .MemDst1(MemDst1), .MemDst2(MemDst2), .MemData(MemData),
        .Halted(Halted), .Illegal(Illegal), .State(State)
    );

    always #5 CLK = ~CLK;

    assign actual = {PCWrite, PCSource, PCAdd, MSPWrite, MSPop, RSPWrite, RSPop,
                     PCRegReset, MSPRegReset, RSPRegReset,
                     ValAWrite, ValBWrite, IRWrite, displayWrite,
                     MemRead1, MemRead2, MemWrite1, MemWrite2,
                     MemDst1, MemDst2, MemData, Halted, Illegal};

    // Control word for each micro-step, straight from the instruction table.
    function automatic outs_t expectWord(kind_t k);
        outs_t o = '0;
        case (k)
            K_INIT:     begin o.PCRegReset = 1; o.MSPRegReset = 1; o.RSPRegReset = 1; end
            K_FETCH:    begin o.MemRead1 = 1; o.IRWrite = 1; o.PCWrite = 1; end
            K_POP_DEC:  begin o.MSPWrite = 1; o.MSPop = 1; end
            K_POPA_RD:  begin o.MemRead1 = 1; o.MemDst1 = 2'b01; o.ValAWrite = 1; end
            K_POPB_RD:  begin o.MemRead2 = 1; o.ValBWrite = 1; end
            K_PUSH_ALU: begin o.MemWrite1 = 1; o.MemDst1 = 2'b01; o.MemData = 3'b001; end
            K_PUSH_IMM: begin o.MemWrite1 = 1; o.MemDst1 = 2'b01; o.MemData = 3'b010; end
            K_PUSH_INC: o.MSPWrite = 1;
            K_BRANCH:   begin o.PCWrite = 1; o.PCAdd = 1; end
            K_CALL_WR:  begin o.MemWrite2 = 1; o.MemDst2 = 2'b01; end
            K_CALL_JMP: begin o.RSPWrite = 1; o.PCWrite = 1; o.PCAdd = 1; end
            K_RET_DEC:  begin o.RSPWrite = 1; o.RSPop = 1; end
            K_RET_RD:   begin o.MemRead1 = 1; o.MemDst1 = 2'b10; o.ValAWrite = 1; end
            K_RET_JMP:  begin o.PCWrite = 1; o.PCSource = 1; end
            K_DISP:     o.displayWrite = 1;
            K_HALT:     o.Halted = 1;
            K_ILL:      o.Illegal = 1;
            default:    o = '0;
        endcase
        return o;
    endfunction

    task automatic checkOutput(input string tag, input outs_t act, input outs_t exp);
        nChecks++;
        if (act !== exp)
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        else
            nPass++;
    endtask

    always @(negedge CLK) begin
        if (expQ.size() > 0) begin
            outs_t e;
            string t;
            e = expQ.pop_front();
            t = tagQ.pop_front();
            checkOutput(t, actual, e);
        end
    end

    task automatic pushExp(input string tag, input kind_t k);
        expQ.push_back(expectWord(k));
        tagQ.push_back(tag);
    endtask

    // Asynchronous reset check, then exactly one INIT cycle before FETCH.
    task automatic doReset(input string tag);
        RESET = 1'b1;
        #1;
        checkOutput({tag, " async"}, actual, expectWord(K_INIT));
        @(posedge CLK); #1;
        RESET = 1'b0;
        pushExp({tag, " init"}, K_INIT);
        @(posedge CLK); #1;
    endtask

    // bzMode: 0 random ValA, 1 force zero, 2 force nonzero at the BZ test.
    task automatic applyStimulus(input logic [15:0] ir, input int bzMode, input string name);
        kind_t       seq[$];
        int          bzIdx = -1;
        logic [15:0] bzVal;
        int          idle = $urandom_range(0, 2);
        for (int i = 0; i < idle; i++) begin
            pushExp($sformatf("%s idle%0d", name, i), K_ZERO);
            Run = 1'b0;
            IROut = 16'($urandom);
            ValAOut = 16'($urandom);
            @(posedge CLK); #1;
        end
        case (bzMode)
            1:       bzVal = 16'h0000;
            2:       bzVal = 16'($urandom_range(1, 65535));
            default: bzVal = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'($urandom_range(1, 65535));
        endcase
        seq.push_back(K_FETCH);
        seq.push_back(K_ZERO);
        case (ir[15:12])
            4'h0: begin
                seq.push_back(K_POP_DEC); seq.push_back(K_POPA_RD);
                seq.push_back(K_POP_DEC); seq.push_back(K_POPB_RD);
                seq.push_back(K_ZERO);
                seq.push_back(K_PUSH_ALU); seq.push_back(K_PUSH_INC);
            end
            4'h1: begin seq.push_back(K_PUSH_IMM); seq.push_back(K_PUSH_INC); end
            4'h2: begin seq.push_back(K_POP_DEC); seq.push_back(K_POPA_RD); end
            4'h3: seq.push_back(K_BRANCH);
            4'h4: begin
                seq.push_back(K_POP_DEC); seq.push_back(K_POPA_RD);
                bzIdx = seq.size();
                seq.push_back(K_ZERO);
                if (bzVal == 16'h0000) seq.push_back(K_BRANCH);
            end
            4'h5: begin seq.push_back(K_CALL_WR); seq.push_back(K_CALL_JMP); end
            4'h6: begin
                seq.push_back(K_RET_DEC); seq.push_back(K_RET_RD); seq.push_back(K_RET_JMP);
            end
            4'h7: for (int i = 0; i < 20; i++) seq.push_back(K_HALT);
            4'h8: begin
                seq.push_back(K_POP_DEC); seq.push_back(K_POPA_RD); seq.push_back(K_DISP);
            end
            default: for (int i = 0; i < 20; i++) seq.push_back(K_ILL);
        endcase
        foreach (seq[i]) pushExp($sformatf("%s %04h cyc%0d", name, ir, i), seq[i]);
        foreach (seq[i]) begin
            Run = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            IROut = ir;
            ValAOut = (i == bzIdx) ? bzVal : 16'($urandom);
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, queue depth %0d", expQ.size());
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] legalOps[8] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8};
        @(posedge CLK); #1;
        checkOutput("held reset", actual, expectWord(K_INIT));
        doReset("reset");

        applyStimulus(16'h1005, 0, "PUSHI");
        applyStimulus(16'h0000, 0, "ALU");
        applyStimulus(16'h4003, 1, "BZ taken");
        applyStimulus(16'h4003, 2, "BZ not taken");
        applyStimulus(16'h5010, 0, "CALL");
        applyStimulus(16'h6000, 0, "RET");
        applyStimulus(16'h8000, 0, "DISP");
        applyStimulus(16'h2000, 0, "POP");
        applyStimulus(16'h3FFE, 0, "JMP");

        for (int n = 0; n < 60; n++) begin
            logic [3:0] op;
            op = legalOps[$urandom_range(0, 7)];
            applyStimulus({op, 12'($urandom)}, 0, "rand");
        end

        applyStimulus(16'h7000, 0, "HALT");
        doReset("halt reset");
        applyStimulus(16'hA000, 0, "ILLEGAL");
        doReset("illegal reset");
        applyStimulus({4'($urandom_range(9, 15)), 12'h123}, 0, "ILLEGAL rand");
        doReset("illegal rand reset");

        // Stop an ALU instruction in POPA_RD and reset asynchronously.
        pushExp("midALU fetch", K_FETCH);
        pushExp("midALU decode", K_ZERO);
        pushExp("midALU popdec", K_POP_DEC);
        for (int i = 0; i < 3; i++) begin
            Run = (i == 0) ? 1'b1 : 1'b0;
            IROut = 16'h0000;
            @(posedge CLK); #1;
        end
        doReset("midALU reset");
        applyStimulus(16'h1005, 0, "PUSHI after reset");

        for (int i = 0; i < 5 && expQ.size() > 0; i++) @(posedge CLK);
        nChecks++;
        if (expQ.size() != 0)
            $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
        else
            nPass++;

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
